// File: rtl/cpu_cycle_sequencer_pkg.sv
// cpu_cycle_sequencer_pkg: state codes and button indices shared by the instruction-cycle sequencer
package cpu_cycle_sequencer_pkg;
  typedef enum logic [1:0] {
    SEQ_RUN  = 2'd0,
    SEQ_WAIT = 2'd1,
    SEQ_LOAD = 2'd2
  } seq_state_t;
  localparam int BTN_PAUSE  = 0;
  localparam int BTN_STEP   = 1;
  localparam int BTN_CANCEL = 2;
endpackage

// File: rtl/cpu_cycle_sequencer_input_conditioner.sv
// cpu_cycle_sequencer_input_conditioner: synchronises, debounces and rise-detects one async button
module cpu_cycle_sequencer_input_conditioner #(
  parameter int DEB_MAX  = 250000,
  parameter int SYNC_LEN = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic i_async,
  output logic o_rise
);
  localparam int DW = $clog2(DEB_MAX + 1);
  logic [SYNC_LEN-1:0] r_sync;
  logic [DW-1:0]       r_cnt;
  logic                r_deb;
  logic                w_s;
  logic                w_diff;
  logic                w_accept;
  assign w_s      = r_sync[SYNC_LEN-1];
  assign w_diff   = w_s != r_deb;
  // a new level is accepted once it has differed from the debounced one for DEB_MAX cycles
  assign w_accept = w_diff && (r_cnt == DW'(DEB_MAX - 1));
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_deb  <= 1'b0;
      o_rise <= 1'b0;
    end else begin
      r_sync <= (r_sync << 1) | SYNC_LEN'(i_async);
      r_cnt  <= (!w_diff || w_accept) ? '0 : r_cnt + DW'(1);
      r_deb  <= w_accept ? w_s : r_deb;
      o_rise <= w_accept && w_s;
    end
  end
endmodule

// File: rtl/cpu_cycle_sequencer.sv
// cpu_cycle_sequencer: issues the one-cycle go enable per instruction, stalling on Din reads
module cpu_cycle_sequencer
  import cpu_cycle_sequencer_pkg::*;
#(
  parameter int CNT_MAX  = 12500000,
  parameter int DEB_MAX  = 250000,
  parameter int SYNC_LEN = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Turbo,
  input  logic       Sample,
  input  logic [2:0] Btns,
  input  logic [7:0] Din,
  input  logic       wait_req,
  output logic       go,
  output logic       din_load,
  output logic [7:0] din_q,
  output logic       Dval,
  output logic [3:0] Debug
);
  localparam int CW = $clog2(CNT_MAX + 1);
  seq_state_t          r_state;
  seq_state_t          w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [SYNC_LEN-1:0] r_turbo_sync;
  logic [7:0]          r_din_sync [SYNC_LEN];
  logic                r_paused;
  logic [3:0]          w_raw;
  logic [3:0]          w_rise;
  logic                w_turbo_s;
  logic [7:0]          w_din_s;
  logic                w_sample_rise;
  logic                w_pause_rise;
  logic                w_step_rise;
  logic                w_cancel_rise;
  logic                w_tick;
  logic                w_opp;
  logic                w_take;
  logic                w_go_nxt;
  logic                w_load_nxt;
  logic                w_dval_nxt;
  logic [7:0]          w_dinq_nxt;
  assign w_raw = {Btns, Sample};
  for (genvar i = 0; i < 4; i++) begin : g_cond
    cpu_cycle_sequencer_input_conditioner #(
      .DEB_MAX (DEB_MAX),
      .SYNC_LEN(SYNC_LEN)
    ) u_cond (
      .Clock  (Clock),
      .Reset  (Reset),
      .i_async(w_raw[i]),
      .o_rise (w_rise[i])
    );
  end
  assign w_sample_rise = w_rise[0];
  assign w_pause_rise  = w_rise[1+BTN_PAUSE];
  assign w_step_rise   = w_rise[1+BTN_STEP];
  assign w_cancel_rise = w_rise[1+BTN_CANCEL];
  assign w_turbo_s     = r_turbo_sync[SYNC_LEN-1];
  assign w_din_s       = r_din_sync[SYNC_LEN-1];
  assign w_tick        = r_cnt == '0;
  // a step arriving with a pause toggle is dropped
  assign w_opp  = r_paused ? (w_step_rise && !w_pause_rise) : (w_tick || w_turbo_s);
  assign w_take = w_sample_rise || w_cancel_rise;
  assign Debug  = {r_paused, r_state, w_turbo_s};
  always_ff @(posedge Clock) begin
    if (Reset) r_state <= SEQ_RUN;
    else r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state == SEQ_RUN  ? ((w_opp && wait_req) ? SEQ_WAIT : SEQ_RUN) :
                  r_state == SEQ_WAIT ? (w_take ? SEQ_LOAD : SEQ_WAIT) : SEQ_RUN;
  end
  always_comb begin
    w_load_nxt = (r_state == SEQ_WAIT) && w_take;
    w_go_nxt   = ((r_state == SEQ_RUN) && w_opp && !wait_req) || w_load_nxt;
    w_dval_nxt = ((r_state == SEQ_RUN) && w_opp && wait_req) ? 1'b0 :
                 (r_state == SEQ_LOAD) ? 1'b1 : Dval;
    w_dinq_nxt = w_load_nxt ? (w_sample_rise ? w_din_s : 8'h00) : din_q;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cnt        <= '0;
      r_turbo_sync <= '0;
      for (int k = 0; k < SYNC_LEN; k++) r_din_sync[k] <= 8'h00;
      r_paused     <= 1'b0;
      go           <= 1'b0;
      din_load     <= 1'b0;
      din_q        <= 8'h00;
      Dval         <= 1'b1;
    end else begin
      r_cnt         <= (r_cnt == CW'(CNT_MAX)) ? '0 : r_cnt + CW'(1);
      r_turbo_sync  <= (r_turbo_sync << 1) | SYNC_LEN'(Turbo);
      r_din_sync[0] <= Din;
      for (int k = 1; k < SYNC_LEN; k++) r_din_sync[k] <= r_din_sync[k-1];
      r_paused      <= r_paused ^ w_pause_rise;
      go            <= w_go_nxt;
      din_load      <= w_load_nxt;
      din_q         <= w_dinq_nxt;
      Dval          <= w_dval_nxt;
    end
  end
endmodule
